// File: rtl/seq_shifter_pkg.sv
// rtl/seq_shifter_pkg.sv - shared width, mode and state encodings for seq_shifter
package seq_shifter_pkg;

  localparam int WIDTH   = 16;
  localparam int COUNT_W = 4;

  typedef logic [WIDTH-1:0]   word_t;
  typedef logic [COUNT_W-1:0] count_t;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_LEFT = 2'b01,
    MODE_LSR  = 2'b10,
    MODE_ASR  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shifter.sv
// rtl/shifter.sv - combinational single-bit shift of one word in the selected mode
module shifter
  import seq_shifter_pkg::*;
(
  input  word_t din,
  input  mode_t mode,
  output word_t dout
);

  always_comb begin
    dout = din;
    case (mode)
      MODE_LEFT: dout = {din[WIDTH-2:0], 1'b0};
      MODE_LSR:  dout = {1'b0, din[WIDTH-1:1]};
      MODE_ASR:  dout = {din[WIDTH-1], din[WIDTH-1:1]};
      default:   dout = din;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle shifter: one bit per clock, N shifts per request
// Operands are captured on the accepted start edge; inputs are ignored while busy.
module seq_shifter
  import seq_shifter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       shift,
  input  logic [3:0]       amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sout
);

  state_t state;
  mode_t  mode;
  count_t count;
  word_t  step;

  shifter u_step (
    .din  (sout),
    .mode (mode),
    .dout (step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      mode  <= MODE_PASS;
      count <= '0;
      sout  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sout  <= in;
            mode  <= mode_t'(shift);
            count <= amount;
            busy  <= 1'b1;
            // pass mode and zero distance skip straight to the result cycle
            if (amount != '0 && mode_t'(shift) != MODE_PASS) begin
              state <= ST_SHIFT;
              done  <= 1'b0;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          sout  <= step;
          count <= count - count_t'(1);
          if (count == count_t'(1)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - randomized self-checking bench for seq_shifter
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] din = '0;
  logic [1:0]  shift = '0;
  logic [3:0]  amount = '0;
  logic        busy;
  logic        done;
  logic [15:0] sout;

  int n_checks = 0;
  int n_pass   = 0;

  seq_shifter dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .in     (din),
    .shift  (shift),
    .amount (amount),
    .busy   (busy),
    .done   (done),
    .sout   (sout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] ref_result(input logic [15:0] v, input logic [1:0] m, input int n);
    int u;
    int r;
    u = int'(v);
    case (m)
      2'b01: r = (u * (1 << n)) % 65536;
      2'b10: r = u / (1 << n);
      2'b11: begin
        r = u / (1 << n);
        if (v[15]) r = r + (65536 - (65536 >> n));
      end
      default: r = u;
    endcase
    return 16'(r);
  endfunction

  function automatic int ref_latency(input logic [1:0] m, input int n);
    return (m == 2'b00 || n == 0) ? 1 : n + 1;
  endfunction

  // called at a negedge; first edge after the call is the capture edge
  task automatic run_op(input logic [15:0] v, input logic [1:0] m, input logic [3:0] n);
    logic [15:0] exp_v;
    int exp_lat;
    int edges;
    exp_v   = ref_result(v, m, int'(n));
    exp_lat = ref_latency(m, int'(n));
    start  = 1'b1;
    din    = v;
    shift  = m;
    amount = n;
    @(negedge clk);
    edges = 1;
    while (!done && edges < 40) begin
      check("busy_during_op", int'(busy), 1);
      start  = 1'($urandom_range(0, 1));
      din    = 16'($urandom);
      shift  = 2'($urandom_range(0, 3));
      amount = 4'($urandom_range(0, 15));
      @(negedge clk);
      edges++;
    end
    check("latency", edges, exp_lat);
    check("result", int'(sout), int'(exp_v));
    check("busy_at_done", int'(busy), 1);
    start = 1'b0;
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("idle_after_done", int'(busy), 0);
    @(negedge clk);
    check("sout_held", int'(sout), int'(exp_v));
    check("still_idle", int'(busy) + int'(done), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_sout", int'(sout), 0);
    reset = 1'b0;
    run_op(16'hF0CF, 2'b01, 4'd4);
    run_op(16'hF0CF, 2'b10, 4'd4);
    run_op(16'hF0CF, 2'b11, 4'd4);
    run_op(16'hF0CF, 2'b00, 4'd7);
    run_op(16'hF0CF, 2'b01, 4'd0);
    run_op(16'hF0CF, 2'b01, 4'd15);
    run_op(16'hF0CF, 2'b11, 4'd15);
    run_op(16'h70CF, 2'b11, 4'd15);
    run_op(16'hF0CF, 2'b10, 4'd15);

    start  = 1'b1;
    din    = 16'($urandom);
    shift  = 2'b01;
    amount = 4'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midop_reset_busy", int'(busy), 0);
    check("midop_reset_done", int'(done), 0);
    check("midop_reset_sout", int'(sout), 0);
    @(negedge clk);
    reset = 1'b0;
    run_op(16'h0001, 2'b01, 4'd1);

    for (int i = 0; i < 60; i++) begin
      logic [3:0] n;
      n = 4'($urandom_range(0, 15));
      if (i % 10 == 0) n = 4'd0;
      if (i % 10 == 5) n = 4'd15;
      run_op(16'($urandom), 2'($urandom_range(0, 3)), n);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
